// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 host command receiver: command codes,
// their one-hot encodings, FSM states and the byte-to-command decode.
package uart_rx_pkg;

   localparam logic [7:0] CMD_1 = 8'h01;
   localparam logic [7:0] CMD_2 = 8'h02;
   localparam logic [7:0] CMD_4 = 8'h04;

   localparam logic [2:0] CMD_1_ONEHOT = 3'b001;
   localparam logic [2:0] CMD_2_ONEHOT = 3'b010;
   localparam logic [2:0] CMD_4_ONEHOT = 3'b100;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } rx_state_e;

   // Unknown bytes keep the previous command.
   function automatic logic [2:0] decode_cmd(input logic [7:0] rx_byte,
                                             input logic [2:0] cur_cmd);
      logic [2:0] cmd;
      cmd = cur_cmd;
      case (rx_byte)
         CMD_1:   cmd = CMD_1_ONEHOT;
         CMD_2:   cmd = CMD_2_ONEHOT;
         CMD_4:   cmd = CMD_4_ONEHOT;
         default: cmd = cur_cmd;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-hot command decode and a
// single-cycle rx_done per frame with a valid stop bit.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic       rs232_rx,
   output logic       rx_done,
   output logic [2:0] command
);

   localparam int unsigned BIT_CYCLES  = CLK_FREQ / BAUD;
   localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
   localparam int unsigned CNT_W       = $clog2(BIT_CYCLES);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

   logic             sync1_q, sync2_q, edge_q;
   logic             fall;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic [2:0]       command_q, command_d;
   logic             rx_done_q, rx_done_d;

   // Sync flops reset high so an idle line never looks like a start edge.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         edge_q  <= 1'b1;
      end else begin
         sync1_q <= rs232_rx;
         sync2_q <= sync1_q;
         edge_q  <= sync2_q;
      end
   end

   assign fall = edge_q & ~sync2_q;

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         rx_data_q  <= '0;
         command_q  <= 3'b000;
         rx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         rx_data_q  <= rx_data_d;
         command_q  <= command_d;
         rx_done_q  <= rx_done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q + 1'b1;
      bit_idx_d  = bit_idx_q;
      rx_data_d  = rx_data_q;
      command_d  = command_q;
      rx_done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            baud_cnt_d = '0;
            if (fall) state_d = StStart;
         end
         StStart: begin
            if (baud_cnt_q == HALF_LAST) begin
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               state_d    = sync2_q ? StIdle : StData;
            end
         end
         StData: begin
            if (baud_cnt_q == BIT_LAST) begin
               baud_cnt_d           = '0;
               rx_data_d[bit_idx_q] = sync2_q;
               bit_idx_d            = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) state_d = StStop;
            end
         end
         StStop: begin
            // Leave mid stop bit so a back-to-back start edge is not missed.
            if (baud_cnt_q == BIT_LAST) begin
               baud_cnt_d = '0;
               state_d    = StIdle;
               if (sync2_q) begin
                  rx_done_d = 1'b1;
                  command_d = decode_cmd(rx_data_q, command_q);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign rx_done = rx_done_q;
   assign command = command_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written
// glitch, back-to-back and mid-frame reset sequences.
`timescale 1ns / 1ps
module tb_uart_rx;

   logic       clk_50M;
   logic       rst_n;
   logic       rs232_rx;
   logic       rx_done;
   logic [2:0] command;

   int checks;
   int errors;

   int  pulses;
   int  high_cycles;
   logic done_prev;
   real last_rise;
   real frame_start;

   localparam int BIT_NS = 8681;
   // Edge -> rx_done rise is nominally 82.52 us; sampled on the falling clock edge.
   localparam real LAT_MIN = 82440.0;
   localparam real LAT_MAX = 82620.0;

   typedef struct {
      logic [7:0] data;
      int         bit_ns;
      logic       stop;
      int         gap_ns;
      int         exp_pulses;
      logic [2:0] exp_cmd;
      bit         chk_lat;
   } vec_t;

   vec_t vecs[8];

   uart_rx dut (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .rs232_rx(rs232_rx),
      .rx_done (rx_done),
      .command (command)
   );

   initial clk_50M = 1'b0;
   always #10 clk_50M = ~clk_50M;

   always @(negedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         done_prev <= 1'b0;
      end else begin
         done_prev <= rx_done;
         if (rx_done) high_cycles <= high_cycles + 1;
         if (rx_done && !done_prev) begin
            pulses    <= pulses + 1;
            last_rise <= $realtime;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input int bit_ns, input logic stop);
      frame_start = $realtime;
      rs232_rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rs232_rx = data[i];
         #(bit_ns);
      end
      rs232_rx = stop;
      #(bit_ns);
      rs232_rx = 1'b1;
   endtask

   initial begin
      int p0, h0;
      real lat;
      checks      = 0;
      errors      = 0;
      pulses      = 0;
      high_cycles = 0;
      last_rise   = 0.0;
      frame_start = 0.0;

      vecs[0] = '{8'h01, BIT_NS, 1'b1, 100000, 1, 3'b001, 1'b1};
      vecs[1] = '{8'h02, BIT_NS, 1'b1, 100000, 1, 3'b010, 1'b1};
      vecs[2] = '{8'h04, BIT_NS, 1'b1, 100000, 1, 3'b100, 1'b1};
      vecs[3] = '{8'hFF, BIT_NS, 1'b1, 100000, 1, 3'b100, 1'b1};
      vecs[4] = '{8'h02, BIT_NS, 1'b0, 20000,  0, 3'b100, 1'b0};
      vecs[5] = '{8'h01, 8507,   1'b1, 20000,  1, 3'b001, 1'b0};
      vecs[6] = '{8'h02, 8855,   1'b1, 20000,  1, 3'b010, 1'b0};
      vecs[7] = '{8'h80, BIT_NS, 1'b1, 20000,  1, 3'b010, 1'b0};

      rs232_rx = 1'b1;
      rst_n    = 1'b0;
      #95;
      check("reset_rx_done", int'(rx_done), 0);
      check("reset_command", int'(command), 0);
      rst_n = 1'b1;
      #1003;

      for (int v = 0; v < 8; v++) begin
         p0 = pulses;
         h0 = high_cycles;
         send_frame(vecs[v].data, vecs[v].bit_ns, vecs[v].stop);
         #(vecs[v].gap_ns);
         check($sformatf("vec%0d_pulses", v), pulses - p0, vecs[v].exp_pulses);
         check($sformatf("vec%0d_width", v), high_cycles - h0, vecs[v].exp_pulses);
         check($sformatf("vec%0d_command", v), int'(command), int'(vecs[v].exp_cmd));
         if (vecs[v].chk_lat) begin
            lat = last_rise - frame_start;
            check($sformatf("vec%0d_latency_ns", v),
                  int'(lat >= LAT_MIN && lat <= LAT_MAX) ? int'(lat) : -int'(lat),
                  int'(lat));
         end
      end

      // Short low glitch on an idle line.
      p0 = pulses;
      rs232_rx = 1'b0;
      #2000;
      rs232_rx = 1'b1;
      #30000;
      check("glitch_pulses", pulses - p0, 0);
      check("glitch_command", int'(command), 3'b010);

      // Back-to-back frames with no idle gap.
      p0 = pulses;
      h0 = high_cycles;
      send_frame(8'h01, BIT_NS, 1'b1);
      send_frame(8'h04, BIT_NS, 1'b1);
      #20000;
      check("b2b_pulses", pulses - p0, 2);
      check("b2b_width", high_cycles - h0, 2);
      check("b2b_command", int'(command), 3'b100);

      // Reset during bit 4 of a 0x02 frame.
      p0 = pulses;
      rs232_rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         rs232_rx = (i == 1) ? 1'b1 : 1'b0;
         #(BIT_NS);
      end
      rs232_rx = 1'b0;
      #(BIT_NS / 2);
      rst_n = 1'b0;
      #1;
      check("midreset_command", int'(command), 0);
      check("midreset_rx_done", int'(rx_done), 0);
      rs232_rx = 1'b1;
      #200;
      rst_n = 1'b1;
      #90000;
      check("aborted_pulses", pulses - p0, 0);
      check("aborted_command", int'(command), 0);
      p0 = pulses;
      send_frame(8'h01, BIT_NS, 1'b1);
      #20000;
      check("after_reset_pulses", pulses - p0, 1);
      check("after_reset_command", int'(command), 3'b001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
